// File: rtl/range_frame_sender.sv
// Buffers up to DEPTH samples, then streams them as one go..finish framed burst
// and reports the unsigned range (max-min) of the samples in that frame.
module range_frame_sender #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     start,
    output logic [WIDTH-1:0]         data_out,
    output logic                     go,
    output logic                     finish,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         frame_range,
    output logic                     empty_err,
    output logic                     wr_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GO     = 2'd1,
        STREAM = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [WIDTH-1:0]   mem_r [DEPTH];
    logic [CW-1:0]      count_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [WIDTH-1:0]   run_max_r;
    logic [WIDTH-1:0]   run_min_r;
    logic [WIDTH-1:0]   frame_range_r;
    logic               empty_err_r;
    logic               wr_drop_r;
    logic               accept_wr_s;
    logic               accept_start_s;
    logic               drop_wr_s;
    logic               empty_start_s;

    function automatic logic [WIDTH-1:0] umax(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [WIDTH-1:0] umin(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Next-state and transaction decode; start has priority over a same-cycle write
    always_comb begin
        state_next_s   = state_r;
        accept_wr_s    = 1'b0;
        accept_start_s = 1'b0;
        drop_wr_s      = 1'b0;
        empty_start_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    drop_wr_s = wr_en;
                    if (count_r != ZERO_C) begin
                        accept_start_s = 1'b1;
                        state_next_s   = GO;
                    end else begin
                        empty_start_s = 1'b1;
                    end
                end else if (wr_en) begin
                    if (count_r < DEPTH_C) begin
                        accept_wr_s = 1'b1;
                    end else begin
                        drop_wr_s = 1'b1;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            GO: begin
                drop_wr_s    = wr_en;
                state_next_s = (count_r > ONE_C) ? STREAM : FIN;
            end
            STREAM: begin
                drop_wr_s = wr_en;
                if ({1'b0, rd_ptr_r} == (count_r - ONE_C)) begin
                    state_next_s = FIN;
                end else begin
                    state_next_s = STREAM;
                end
            end
            FIN: begin
                drop_wr_s    = wr_en;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Fill level, read pointer, running extremes and status flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r       <= ZERO_C;
            rd_ptr_r      <= {AW{1'b0}};
            run_max_r     <= {WIDTH{1'b0}};
            run_min_r     <= {WIDTH{1'b1}};
            frame_range_r <= {WIDTH{1'b0}};
            empty_err_r   <= 1'b0;
            wr_drop_r     <= 1'b0;
        end else begin
            empty_err_r <= empty_start_s;
            wr_drop_r   <= wr_drop_r | drop_wr_s;
            if (accept_wr_s) begin
                count_r   <= count_r + ONE_C;
                run_max_r <= umax(run_max_r, wr_data);
                run_min_r <= umin(run_min_r, wr_data);
            end else if (state_r == FIN) begin
                count_r   <= ZERO_C;
                run_max_r <= {WIDTH{1'b0}};
                run_min_r <= {WIDTH{1'b1}};
            end else begin
                count_r <= count_r;
            end
            if (accept_start_s) begin
                rd_ptr_r      <= {AW{1'b0}};
                frame_range_r <= run_max_r - run_min_r;
            end else if ((state_r == GO) || (state_r == STREAM)) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Sample storage; contents are irrelevant until written, so no reset
    always_ff @(posedge clock) begin
        if (accept_wr_s) begin
            mem_r[count_r[AW-1:0]] <= wr_data;
        end
    end

    // Outputs decoded purely from registered state and datapath
    always_comb begin
        data_out = {WIDTH{1'b0}};
        case (state_r)
            GO, STREAM: data_out = mem_r[rd_ptr_r];
            default:    data_out = {WIDTH{1'b0}};
        endcase
        go          = (state_r == GO);
        finish      = (state_r == FIN);
        busy        = (state_r != IDLE);
        count       = count_r;
        frame_range = frame_range_r;
        empty_err   = empty_err_r;
        wr_drop     = wr_drop_r;
    end

endmodule

// File: doc/range_frame_sender.md
RANGE_FRAME_SENDER -- requirements
Module: range_frame_sender

Interface
REQ-001 Parameter WIDTH, default 16: sample width in bits.
REQ-002 Parameter DEPTH, default 8: buffer capacity in words; power of two, >=2.
REQ-003 clock  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 wr_en  input  1  load request; accepts wr_data into the buffer.
REQ-006 wr_data  input  WIDTH  word to load.
REQ-007 start  input  1  request to transmit the buffered frame.
REQ-008 data_out  output  WIDTH  sample presented to the downstream range consumer.
REQ-009 go  output  1  frame-open strobe; first word valid on data_out in the same cycle.
REQ-010 finish  output  1  frame-close strobe; data_out is 0 and carries no sample.
REQ-011 busy  output  1  high while a frame is in transmission.
REQ-012 count  output  $clog2(DEPTH)+1  words currently buffered.
REQ-013 frame_range  output  WIDTH  expected range (max-min) of the last frame started.
REQ-014 empty_err  output  1  one-cycle pulse: start refused because the buffer was empty.
REQ-015 wr_drop  output  1  sticky: at least one write was discarded.

Function
REQ-016 FSM states: IDLE, GO, STREAM, FIN; all outputs are decoded from registered state/datapath, with no combinational input-to-output path.
REQ-017 IDLE, wr_en=1, start=0, count<DEPTH: buf[count]<=wr_data; count+1; run_max/run_min updated with unsigned compare.
REQ-018 IDLE, wr_en=1, count==DEPTH: write discarded; wr_drop<=1.
REQ-019 wr_en=1 in any state other than IDLE: write discarded; wr_drop<=1.
REQ-020 IDLE, start=1, count>0: next state GO; frame_range<=run_max-run_min; rd_ptr<=0.
REQ-021 IDLE, start=1, wr_en=1 same cycle: start wins; write discarded; wr_drop<=1 (empty-check uses count before the edge).
REQ-022 IDLE, start=1, count==0: stay IDLE; empty_err=1 for exactly the next cycle.
REQ-023 GO (1 cycle): go=1, data_out=buf[0]; next STREAM if count>1, else FIN.
REQ-024 STREAM: data_out=buf[rd_ptr], one word per cycle for words 1..count-1; after word count-1, next FIN.
REQ-025 FIN (1 cycle): finish=1, data_out=0; then IDLE with count<=0, run_max<=0, run_min<=all-ones.
REQ-026 Frame timing: start accepted at edge k -> go in cycle k+1 -> finish in cycle k+1+count; total frame count+1 cycles.
REQ-027 go and finish are never high in the same cycle; each is high for exactly one cycle per frame.
REQ-028 busy=1 in GO, STREAM and FIN; otherwise 0.
REQ-029 start while busy is ignored and has no side effects.
REQ-030 data_out=0 in IDLE.
REQ-031 frame_range arithmetic is unsigned modulo 2^WIDTH; max>=min always holds, so there is no wrap; single-word frame gives 0.
REQ-032 frame_range holds its value until the next accepted start.

Reset
REQ-033 On reset, in any state: state=IDLE, go=0, finish=0, busy=0, data_out=0, count=0, frame_range=0, empty_err=0, wr_drop=0, run_max=0, run_min=all-ones.
REQ-034 Reset asserted mid-frame aborts the frame immediately and no finish is emitted; buffer contents are don't-care after reset.

Verification
REQ-035 Load 5,20,3,9, then start -> go with data_out=5; then 20,3,9; finish on the 5th cycle after the start edge; frame_range=17; count=0 after FIN.
REQ-036 Load single word 0xFFFF, start -> go with data 0xFFFF, finish next cycle, frame_range=0.
REQ-037 start with empty buffer -> empty_err one-cycle pulse, go never asserted, busy stays 0.
REQ-038 Load DEPTH words plus one extra -> extra dropped, wr_drop=1, count=DEPTH; frame carries DEPTH words.
REQ-039 wr_en and start in the same cycle with 2 words buffered -> 2-word frame, wr_drop=1; writes during busy -> dropped.
REQ-040 Reset asserted during STREAM -> go/finish/busy low immediately, count=0; a new load/start then works normally.
